fetch_sequencer: RTL and testbench
==================================

Name: fetch_sequencer

Overview:
- Sequences instruction fetch for the RV32I core.
- Fetches each instruction word from instruction memory over a req/ack handshake, then drives raw_bits stable to the core, and advances the PC when the core retires the instruction.
- Handles branch/jump redirects, halts on ECALL/EBREAK, and flags faults for misaligned targets and memory timeouts.
- Sits between instruction memory and the core's raw_bits input.

Parameters:
- RESET_PC, 32'h0040_0000, PC value loaded on reset.
- TIMEOUT_CYCLES, 15, maximum REQ cycles without imem_ack before a fault is raised; range 1..255.

Ports:
- clk  input  1  core clock
- rst  input  1  reset
- imem_req  output  1  fetch request, held high until ack
- imem_addr  output  32  fetch address, equals pc while imem_req is high
- imem_ack  input  1  one-cycle pulse; imem_rdata is valid in the same cycle
- imem_rdata  input  32  fetched instruction word
- raw_bits  output  32  instruction word to the core decoder
- instr_valid  output  1  raw_bits holds a valid instruction awaiting retirement
- core_ready  input  1  core retires the current instruction this cycle
- redirect_valid  input  1  taken branch/jump, qualified by core_ready
- redirect_pc  input  32  redirect target
- pc  output  32  address of the current or pending instruction
- halted  output  1  sticky, ECALL/EBREAK reached
- fault  output  1  sticky, misaligned redirect or fetch timeout

Behaviour:
- Reset is asynchronous and active-high. rst is applied asynchronously; release is synchronous to clk.
- Reset values:
  - state=REQ, pc=RESET_PC, raw_bits=0, instr_valid=0, halted=0, fault=0.
  - Timeout counter=0.
  - imem_req is combinational from state, so it is 1 in the first cycle after reset release.
- States: REQ, ISSUE, HALT, FAULT.
- REQ:
  - imem_req=1, imem_addr=pc.
  - Timeout counter increments each cycle without imem_ack.
  - On imem_ack: capture imem_rdata into raw_bits and clear the counter.
    - If imem_rdata is 32'h0000_0073 or 32'h0010_0073, go to HALT.
    - Otherwise go to ISSUE.
  - Ack in the same cycle as the first req is legal (zero-wait memory). Minimum throughput is therefore 2 cycles per instruction.
  - When the counter reaches TIMEOUT_CYCLES without ack, go to FAULT.
- ISSUE:
  - instr_valid=1, imem_req=0, raw_bits held stable.
  - Waits indefinitely for core_ready.
  - On core_ready with redirect_valid=0: pc <= pc+4, wrapping modulo 2^32, then go to REQ.
  - On core_ready with redirect_valid=1:
    - If redirect_pc[1:0]==0: pc <= redirect_pc, then go to REQ.
    - Otherwise: pc unchanged, go to FAULT.
  - redirect_valid without core_ready is ignored.
- HALT:
  - halted=1, instr_valid=1 (the core may observe the ECALL/EBREAK), imem_req=0.
  - core_ready is ignored; pc stays at the ECALL/EBREAK address.
  - Exit only by reset.
- FAULT:
  - fault=1, instr_valid=0, imem_req=0.
  - pc holds the faulting fetch address, or the address of the instruction that issued the bad redirect.
  - Exit only by reset.
- imem_ack outside REQ is ignored and does not change raw_bits.
- Reset asserted mid-handshake abandons the request. A late ack after reset release but before the new REQ cycle cannot occur, because REQ is entered immediately; the memory must drop stale acks on rst.
- pc is registered; raw_bits changes only on a captured ack.

Optional Feature:
- Macro: FETCH_SEQ_RETIRE_CNT_EN.
- When defined:
  - Adds output retire_count, 32 bits, reset to 0.
  - Increments by 1 on each cycle with state==ISSUE and core_ready=1, including redirected and faulting retirements.
  - Wraps from 32'hFFFF_FFFF to 0.
  - Frozen in HALT and FAULT.
- When undefined: the port and counter are absent, and all other behaviour is identical.

Test Plan:
1. Zero-wait memory returning 32'h0050_0093 (addi x1,x0,5), core_ready tied high:
   - imem_addr is 0x0040_0000, then 0x0040_0004, then 0x0040_0008.
   - One instruction every 2 cycles; instr_valid toggles 0/1.
2. Ack delayed 3 cycles, core_ready held low 4 cycles in ISSUE:
   - imem_req stays high for 4 cycles.
   - raw_bits is stable and instr_valid=1 throughout the stall.
   - pc advances by 4 only on the core_ready cycle.
3. Retire with redirect_valid=1, redirect_pc=0x0040_0100:
   - Next imem_addr is 0x0040_0100.
   - redirect_valid=1 with core_ready=0 has no effect.
4. Redirect to 0x0040_0102:
   - fault=1 the next cycle, imem_req=0, pc unchanged.
   - Stays there until rst, after which pc=0x0040_0000 and fault=0.
5. Fetch returns 32'h0010_0073 (EBREAK):
   - halted=1, instr_valid=1.
   - No further imem_req even with core_ready=1.
   - With FETCH_SEQ_RETIRE_CNT_EN defined, retire_count equals the number of prior retirements.
6. imem_ack never asserted:
   - fault=1 after 15 REQ cycles.
   - Asserting rst in the middle of cycle 8 instead returns the block to REQ at RESET_PC with the counter cleared.

Source files
------------

// File: rtl/fetch_sequencer.sv
// fetch_sequencer: RV32I instruction fetch sequencer with req/ack imem handshake, redirect, halt and fault
// Ports: clk, rst (async active-high); imem_req/imem_addr/imem_ack/imem_rdata memory side;
// raw_bits/instr_valid/core_ready/redirect_valid/redirect_pc core side; pc, halted, fault status.
// Optional macro FETCH_SEQ_RETIRE_CNT_EN adds retire_count (retirements seen in ISSUE).
module fetch_sequencer #(
  parameter logic [31:0] RESET_PC = 32'h0040_0000,
  parameter int TIMEOUT_CYCLES = 15
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:0] raw_bits,
  output logic        instr_valid,
  input  logic        core_ready,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic [31:0] pc,
  output logic        halted,
  output logic        fault
`ifdef FETCH_SEQ_RETIRE_CNT_EN
  ,
  output logic [31:0] retire_count
`endif
);
  typedef enum logic [1:0] {REQ, ISSUE, HALT, FAULT} state_t;
  localparam logic [7:0] TLIM = 8'(TIMEOUT_CYCLES - 1);
  state_t state, next;
  logic [7:0] cnt;
  logic is_sys, retire, bad_target;
  assign is_sys = imem_rdata == 32'h0000_0073 || imem_rdata == 32'h0010_0073;
  assign retire = state == ISSUE && core_ready;
  assign bad_target = redirect_pc[1:0] != 2'b00;
  assign imem_addr = pc;
  always_ff @(posedge clk or posedge rst)
    if (rst) state <= REQ;
    else state <= next;
  // The cycle that would be the TIMEOUT_CYCLES-th without ack is the last REQ cycle.
  always_comb begin
    next = state;
    if (state == REQ) next = imem_ack ? (is_sys ? HALT : ISSUE) : (cnt == TLIM ? FAULT : REQ);
    else if (retire) next = redirect_valid && bad_target ? FAULT : REQ;
  end
  always_comb begin
    imem_req = state == REQ;
    instr_valid = state == ISSUE || state == HALT;
    halted = state == HALT;
    fault = state == FAULT;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      pc <= RESET_PC;
      raw_bits <= '0;
      cnt <= '0;
    end else begin
      if (state == REQ) cnt <= imem_ack ? 8'd0 : cnt + 8'd1;
      if (state == REQ && imem_ack) raw_bits <= imem_rdata;
      if (retire && !redirect_valid) pc <= pc + 32'd4;
      if (retire && redirect_valid && !bad_target) pc <= redirect_pc;
    end
`ifdef FETCH_SEQ_RETIRE_CNT_EN
  always_ff @(posedge clk or posedge rst)
    if (rst) retire_count <= '0;
    else if (retire) retire_count <= retire_count + 32'd1;
`endif
endmodule

// File: tb/tb_fetch_sequencer.sv
// tb_fetch_sequencer: directed stimulus against a behavioural fetch model, compared every cycle
module tb_fetch_sequencer;
  localparam int TO = 15;
  logic clk = 0, rst;
  logic imem_req, imem_ack, instr_valid, core_ready, redirect_valid, halted, fault;
  logic [31:0] imem_addr, imem_rdata, raw_bits, redirect_pc, pc;
  logic [31:0] mem_word;
  int ack_delay, req_cycles;
  int checks = 0, errors = 0;
`ifdef FETCH_SEQ_RETIRE_CNT_EN
  logic [31:0] retire_count;
`endif
  fetch_sequencer #(.RESET_PC(32'h0040_0000), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst(rst), .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack),
    .imem_rdata(imem_rdata), .raw_bits(raw_bits), .instr_valid(instr_valid), .core_ready(core_ready),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc), .pc(pc), .halted(halted), .fault(fault)
`ifdef FETCH_SEQ_RETIRE_CNT_EN
    , .retire_count(retire_count)
`endif
  );
  always #5 clk = ~clk;
  // Memory: acks after ack_delay waiting cycles of a continuous request.
  assign imem_ack = imem_req && req_cycles == ack_delay;
  assign imem_rdata = mem_word;
  always @(posedge clk or posedge rst)
    if (rst) req_cycles <= 0;
    else req_cycles <= (imem_req && !imem_ack) ? req_cycles + 1 : 0;
  // Model: an instruction is either being fetched, held for the core, or the block is stopped.
  logic [31:0] m_pc, m_raw, m_retired;
  logic m_held, m_halted, m_fault;
  int m_wait;
  wire m_fetching = !m_held && !m_halted && !m_fault;
  always @(posedge clk or posedge rst)
    if (rst) begin
      m_pc <= 32'h0040_0000; m_raw <= 0; m_retired <= 0;
      m_held <= 0; m_halted <= 0; m_fault <= 0; m_wait <= 0;
    end else if (m_fetching) begin
      if (imem_ack) begin
        m_raw <= imem_rdata;
        m_wait <= 0;
        if (imem_rdata == 32'h0000_0073 || imem_rdata == 32'h0010_0073) m_halted <= 1;
        else m_held <= 1;
      end else if (m_wait + 1 >= TO) m_fault <= 1;
      else m_wait <= m_wait + 1;
    end else if (m_held && core_ready) begin
      m_retired <= m_retired + 1;
      m_held <= 0;
      if (!redirect_valid) m_pc <= m_pc + 4;
      else if (redirect_pc % 4 != 0) m_fault <= 1;
      else m_pc <= redirect_pc;
    end
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h t=%0t", name, act, exp, $time);
    end
  endtask
  initial forever begin
    @(negedge clk); #1;
    if (!rst) begin
      chk("imem_req", {31'd0, imem_req}, {31'd0, m_fetching});
      if (m_fetching) chk("imem_addr", imem_addr, m_pc);
      chk("raw_bits", raw_bits, m_raw);
      chk("instr_valid", {31'd0, instr_valid}, {31'd0, m_held || m_halted});
      chk("pc", pc, m_pc);
      chk("halted", {31'd0, halted}, {31'd0, m_halted});
      chk("fault", {31'd0, fault}, {31'd0, m_fault});
`ifdef FETCH_SEQ_RETIRE_CNT_EN
      chk("retire_count", retire_count, m_retired);
`endif
    end
  end
  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
    #1;
  endtask
  initial begin
    rst = 1; core_ready = 1; redirect_valid = 0; redirect_pc = 0;
    mem_word = 32'h0050_0093; ack_delay = 0;
    cyc(2); rst = 0;
    chk("t1_req0", {31'd0, imem_req}, 32'd1);
    chk("t1_addr0", imem_addr, 32'h0040_0000);
    chk("t1_raw_reset", raw_bits, 32'd0);
    cyc(1);
    chk("t1_valid", {31'd0, instr_valid}, 32'd1);
    chk("t1_raw", raw_bits, 32'h0050_0093);
    cyc(1);
    chk("t1_addr1", imem_addr, 32'h0040_0004);
    chk("t1_valid0", {31'd0, instr_valid}, 32'd0);
    cyc(2);
    chk("t1_addr2", imem_addr, 32'h0040_0008);
    ack_delay = 3; core_ready = 0;
    cyc(3);
    chk("t2_req4", {31'd0, imem_req}, 32'd1);
    cyc(1);
    chk("t2_issue", {31'd0, instr_valid}, 32'd1);
    cyc(3);
    chk("t2_stall_pc", pc, 32'h0040_0008);
    chk("t2_stall_raw", raw_bits, 32'h0050_0093);
    core_ready = 1;
    cyc(1);
    core_ready = 0;
    chk("t2_pc", pc, 32'h0040_000C);
    ack_delay = 0;
    cyc(1);
    redirect_valid = 1; redirect_pc = 32'h0040_0100;
    cyc(2);
    chk("t3_ignored", pc, 32'h0040_000C);
    core_ready = 1;
    cyc(1);
    core_ready = 0; redirect_valid = 0;
    chk("t3_addr", imem_addr, 32'h0040_0100);
    cyc(1);
    redirect_valid = 1; redirect_pc = 32'h0040_0102; core_ready = 1;
    cyc(1);
    redirect_valid = 0;
    chk("t4_fault", {31'd0, fault}, 32'd1);
    chk("t4_req", {31'd0, imem_req}, 32'd0);
    chk("t4_pc", pc, 32'h0040_0100);
    cyc(3);
    chk("t4_sticky", {31'd0, fault}, 32'd1);
    rst = 1;
    cyc(1);
    rst = 0;
    chk("t4_rst_pc", pc, 32'h0040_0000);
    chk("t4_rst_fault", {31'd0, fault}, 32'd0);
    cyc(4);
    mem_word = 32'h0010_0073;
    cyc(1);
    chk("t5_halted", {31'd0, halted}, 32'd1);
    chk("t5_valid", {31'd0, instr_valid}, 32'd1);
    chk("t5_pc", pc, 32'h0040_0008);
    cyc(3);
    chk("t5_noreq", {31'd0, imem_req}, 32'd0);
`ifdef FETCH_SEQ_RETIRE_CNT_EN
    chk("t5_retired", retire_count, 32'd2);
`endif
    rst = 1;
    cyc(1);
    rst = 0; mem_word = 32'h0050_0093; ack_delay = 255;
    cyc(14);
    chk("t6_req15", {31'd0, imem_req}, 32'd1);
    chk("t6_nofault15", {31'd0, fault}, 32'd0);
    cyc(1);
    chk("t6_fault", {31'd0, fault}, 32'd1);
    chk("t6_pc", pc, 32'h0040_0000);
    rst = 1;
    cyc(1);
    rst = 0;
    cyc(7);
    rst = 1;
    #1;
    chk("t6_midrst_req", {31'd0, imem_req}, 32'd1);
    cyc(1);
    rst = 0;
    cyc(14);
    chk("t6_cleared", {31'd0, fault}, 32'd0);
    cyc(1);
    chk("t6_fault2", {31'd0, fault}, 32'd1);
    rst = 1;
    cyc(1);
    rst = 0; ack_delay = TO - 1;
    cyc(15);
    chk("t6_lastack", {31'd0, instr_valid}, 32'd1);
    chk("t6_lastack_fault", {31'd0, fault}, 32'd0);
    cyc(2);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
